axil_ram_ctrl: RTL and testbench
================================

Name: axil_ram_ctrl

Overview:
Parametrised AXI-Lite slave RAM, successor to the fixed 16-bit/32-bit AXI-Lite RAM.
- Generalises data width, memory depth, base address and read latency.
- Adds address range checking with SLVERR responses, and fair read/write arbitration for a single-port array.
- Sits behind the AXI-Lite interconnect as scratch/data memory for the core's simulation SoC.

Parameters:
ADDR_WIDTH, 16, AXI-Lite address width in bits
DATA_WIDTH, 32, data width in bits; legal values 32 or 64
MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two
BASE_ADDR, 0, byte address mapped to word 0
READ_LATENCY, 1, cycles from read grant to rvalid; range 1..4

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
s_axil_awaddr  input  ADDR_WIDTH  write address
s_axil_awprot  input  3  ignored
s_axil_awvalid  input  1  AW valid
s_axil_awready  output  1  AW ready
s_axil_wdata  input  DATA_WIDTH  write data
s_axil_wstrb  input  DATA_WIDTH/8  byte strobes
s_axil_wvalid  input  1  W valid
s_axil_wready  output  1  W ready
s_axil_bresp  output  2  write response
s_axil_bvalid  output  1  B valid
s_axil_bready  input  1  B ready
s_axil_araddr  input  ADDR_WIDTH  read address
s_axil_arprot  input  3  ignored
s_axil_arvalid  input  1  AR valid
s_axil_arready  output  1  AR ready
s_axil_rdata  output  DATA_WIDTH  read data
s_axil_rresp  output  2  read response
s_axil_rvalid  output  1  R valid
s_axil_rready  input  1  R ready

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset state:
  - all readies, bvalid and rvalid are 0 while rst is high;
  - bresp, rresp and rdata reset to 0;
  - memory contents are not reset;
  - arbiter priority resets to write.
- Any transaction in flight when rst asserts is dropped; no response is issued.
- Address decode:
  - word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low byte-offset bits are ignored;
  - an address is in range iff addr >= BASE_ADDR and index < MEM_DEPTH.
- AW and W are accepted independently, each into a one-entry holding register.
  - awready = !aw_held; wready = !w_held (high from the first cycle after reset).
  - Either channel may arrive first; there is no combinational valid-to-ready path.
- Write commit: eligible when aw_held, w_held, and B is empty (bvalid=0).
  - When granted, bytes with wstrb=1 are written at the index.
  - bvalid rises the next cycle. bresp = OKAY (2'b00) in range, SLVERR (2'b10) out of range.
  - Out-of-range writes do not modify memory.
  - Both holding registers clear on commit.
- Minimum write latency: bvalid is asserted 2 cycles after the later of the AW/W handshakes.
- B is held until bready. A new commit cannot occur while bvalid=1; the holding registers stay full, so further AW/W are stalled.
- Read path: arready = !ar_held && read pipeline empty && !rvalid, so at most one read is outstanding.
  - AR handshake in cycle N sets ar_held.
  - Read eligible in N+1; once granted, rvalid rises READ_LATENCY cycles later.
  - Minimum: AR handshake in N -> rvalid in N+1+READ_LATENCY.
  - rresp = OKAY with array data in range; SLVERR with rdata=0 out of range.
  - rdata/rresp are stable while rvalid=1 and rready=0.
- Arbitration: single-port array, at most one access per cycle.
  - If both write commit and read are eligible in the same cycle, the priority holder wins.
  - Priority toggles to the other side after every contended grant.
  - An uncontended grant leaves priority unchanged.
- Write followed by a read to the same address returns the new data; read-after-write ordering follows grant order.
- Partial strobes: wstrb=0 with a valid address completes with OKAY and changes no bytes.

Optional Feature:
Macro: AXIL_RAM_ERRCNT_EN
- Defined:
  - adds output err_count [15:0];
  - increments by 1 on each B or R beat handshaked with SLVERR;
  - if a B and an R SLVERR handshake occur in the same cycle, increments by 2;
  - saturates at 16'hFFFF and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then AW addr 0x0010 and W data 0xDEADBEEF strb 4'hF in the same cycle -> bvalid 2 cycles later, bresp 2'b00. Then read 0x0010 (READ_LATENCY=1) -> rvalid 2 cycles after the AR handshake, rdata 0xDEADBEEF, rresp 2'b00.
- W sent 3 cycles before AW (addr 0x0020, data 0x11223344) -> exactly one bvalid, 2 cycles after the AW handshake. Then write 0xAABBCCDD to 0x0020 with strb 4'b0101 -> readback 0x11BB33DD.
- Write to 0x1000 (MEM_DEPTH=1024, 32-bit) -> bresp 2'b10 and memory unchanged. Read 0x1000 -> rresp 2'b10, rdata 0. With AXIL_RAM_ERRCNT_EN defined, err_count = 2.
- Write and read both eligible in the same cycle, repeated 4 times -> grant order W, R, W, R. The read of the same address sees the write only when the write was granted first.
- Hold bready=0 for 5 cycles after a write, then issue a second AW/W -> awready/wready stay 0, no second commit. The second bvalid appears only after the first B handshake plus 2 cycles.
- READ_LATENCY=3, issue a read, assert rst 2 cycles after the AR handshake -> no rvalid ever appears. The first post-reset cycle has arready=1.

Source files
------------

// File: rtl/axil_ram_ctrl.sv
// AXI-Lite slave RAM: independent AW/W holding registers, one outstanding read,
// fair read/write arbitration onto a single-port array. Optional SLVERR counter: AXIL_RAM_ERRCNT_EN.
module axil_ram_ctrl #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEM_DEPTH    = 1024,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int          READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef AXIL_RAM_ERRCNT_EN
    output logic [15:0]             err_count,
`endif
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] word;
        word = (a - BASE) >> OFFS_W;
        return (a >= BASE) && ((word >> IDX_W) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE) >> OFFS_W);
    endfunction

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    aw_held_q, w_held_q, ar_held_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    prio_wr_q, prio_wr_d;

    logic [READ_LATENCY-1:0] rd_vld_q;
    logic [READ_LATENCY-1:0] stg_in_vld;
    logic [DATA_WIDTH-1:0]   rd_dat_q [READ_LATENCY];
    logic [1:0]              rd_rsp_q [READ_LATENCY];

    logic aw_hs, w_hs, ar_hs;
    logic wr_elig, rd_elig, wr_grant, rd_grant;
    logic wr_ok, rd_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    // Readies depend only on state and rst, never on the incoming valids.
    assign s_axil_awready = !rst && !aw_held_q;
    assign s_axil_wready  = !rst && !w_held_q;
    assign s_axil_arready = !rst && !ar_held_q && !(|rd_vld_q);

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid  && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    assign wr_ok  = addr_ok(aw_addr_q);
    assign rd_ok  = addr_ok(ar_addr_q);
    assign wr_idx = addr_idx(aw_addr_q);
    assign rd_idx = addr_idx(ar_addr_q);

    always_comb begin
        wr_elig   = aw_held_q && w_held_q && !bvalid_q;
        rd_elig   = ar_held_q;
        wr_grant  = wr_elig && (!rd_elig || prio_wr_q);
        rd_grant  = rd_elig && (!wr_elig || !prio_wr_q);
        prio_wr_d = (wr_elig && rd_elig) ? !prio_wr_q : prio_wr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            prio_wr_q <= 1'b1;
        end else begin
            if (aw_hs)         aw_held_q <= 1'b1;
            else if (wr_grant) aw_held_q <= 1'b0;
            if (w_hs)          w_held_q  <= 1'b1;
            else if (wr_grant) w_held_q  <= 1'b0;
            if (ar_hs)         ar_held_q <= 1'b1;
            else if (rd_grant) ar_held_q <= 1'b0;

            if (wr_grant) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_bready) begin
                bvalid_q <= 1'b0;
            end
            prio_wr_q <= prio_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr_q <= s_axil_awaddr;
        if (w_hs) begin
            w_data_q <= s_axil_wdata;
            w_strb_q <= s_axil_wstrb;
        end
        if (ar_hs) ar_addr_q <= s_axil_araddr;
    end

    always_ff @(posedge clk) begin
        if (wr_grant && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) mem_q[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
        end
    end

    always_comb begin
        stg_in_vld    = '0;
        stg_in_vld[0] = rd_grant;
        for (int k = 1; k < READ_LATENCY; k++) stg_in_vld[k] = rd_vld_q[k-1];
    end

    // Read pipeline: stage 0 samples the array at grant, last stage holds until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_dat_q[k] <= '0;
                rd_rsp_q[k] <= RESP_OKAY;
            end
        end else begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                if (stg_in_vld[k])
                    rd_vld_q[k] <= 1'b1;
                else if (k != READ_LATENCY - 1 || s_axil_rready)
                    rd_vld_q[k] <= 1'b0;
            end
            if (rd_grant) begin
                rd_dat_q[0] <= rd_ok ? mem_q[rd_idx] : '0;
                rd_rsp_q[0] <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                if (stg_in_vld[k]) begin
                    rd_dat_q[k] <= rd_dat_q[k-1];
                    rd_rsp_q[k] <= rd_rsp_q[k-1];
                end
            end
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rd_vld_q[READ_LATENCY-1];
    assign s_axil_rdata  = rd_dat_q[READ_LATENCY-1];
    assign s_axil_rresp  = rd_rsp_q[READ_LATENCY-1];

`ifdef AXIL_RAM_ERRCNT_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic        b_err, r_err;
    logic [15:0] err_cnt_q;

    assign b_err = bvalid_q && s_axil_bready && (bresp_q == RESP_SLVERR);
    assign r_err = s_axil_rvalid && s_axil_rready && (s_axil_rresp == RESP_SLVERR);

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= sat_add16(err_cnt_q, {1'b0, b_err} + {1'b0, r_err});
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_axil_ram_ctrl.sv
// Directed bench for axil_ram_ctrl: latency, strobes, range errors, arbitration,
// B back-pressure, and reset during a READ_LATENCY=3 read.
module tb_axil_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
`ifdef AXIL_RAM_ERRCNT_EN
    logic [15:0] err_count, err_count3;
`endif

    logic        rst3, arvalid3, rready3;
    logic [15:0] araddr3;
    logic        awready3, wready3, bvalid3, arready3, rvalid3;
    logic [1:0]  bresp3, rresp3;
    logic [31:0] rdata3;

    int n_checks = 0;
    int n_fail   = 0;

    axil_ram_ctrl u_dut (
        .clk(clk), .rst(rst),
`ifdef AXIL_RAM_ERRCNT_EN
        .err_count(err_count),
`endif
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
        .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready)
    );

    axil_ram_ctrl #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3),
`ifdef AXIL_RAM_ERRCNT_EN
        .err_count(err_count3),
`endif
        .s_axil_awaddr(16'h0000), .s_axil_awprot(3'b000), .s_axil_awvalid(1'b0),
        .s_axil_awready(awready3), .s_axil_wdata(32'h0), .s_axil_wstrb(4'h0),
        .s_axil_wvalid(1'b0), .s_axil_wready(wready3), .s_axil_bresp(bresp3),
        .s_axil_bvalid(bvalid3), .s_axil_bready(1'b1), .s_axil_araddr(araddr3),
        .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid3), .s_axil_arready(arready3),
        .s_axil_rdata(rdata3), .s_axil_rresp(rresp3), .s_axil_rvalid(rvalid3),
        .s_axil_rready(rready3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        logic aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 16) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 16) begin
            tick();
            n++;
        end
        chk("wr_bvalid_seen", bvalid, 1'b1);
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        logic ar_hs;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 16) begin
            ar_hs = arready;
            tick();
            if (ar_hs) arvalid = 1'b0;
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 16) begin
            tick();
            n++;
        end
        chk("rd_rvalid_seen", rvalid, 1'b1);
        d = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    task automatic contend(input logic [31:0] d, output int bc, output int rc, output logic [31:0] rd);
        awaddr = 16'h0040; wdata = d; wstrb = 4'hF; araddr = 16'h0040;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        chk("ct_readies", {awready, wready, arready}, 3'b111);
        bc = -1; rc = -1; rd = '0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            if (bvalid && bc < 0) bc = c;
            if (rvalid && rc < 0) begin
                rc = c;
                rd = rdata;
            end
        end
        bready = 1'b0; rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] data;
    int          bc, rc;
    logic [31:0] ct_data [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    int          ct_bc   [4] = '{2, 3, 2, 3};
    int          ct_rc   [4] = '{3, 2, 3, 2};
    logic [31:0] ct_rd   [4] = '{32'hA1, 32'hA1, 32'hA3, 32'hA3};

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        araddr3 = '0; arvalid3 = 1'b0; rready3 = 1'b0;
        tick();
        tick();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_arready3", arready3, 1'b0);
        chk("rst_bvalid3", bvalid3, 1'b0);
        chk("rst_bresp3", bresp3, 2'b00);
`ifdef AXIL_RAM_ERRCNT_EN
        chk("rst_errcnt", err_count, 16'd0);
`endif
        rst = 1'b0; rst3 = 1'b0;
        #1;
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_wready", wready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);
        chk("post_rst_awready3", awready3, 1'b1);
        chk("post_rst_wready3", wready3, 1'b1);

        // AW and W together: bvalid two cycles later
        awaddr = 16'h0010; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w1_bvalid_c1", bvalid, 1'b0);
        chk("w1_awready_held", awready, 1'b0);
        tick();
        chk("w1_bvalid_c2", bvalid, 1'b1);
        chk("w1_bresp", bresp, 2'b00);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("w1_bvalid_done", bvalid, 1'b0);

        araddr = 16'h0010; arvalid = 1'b1;
        chk("r1_arready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        chk("r1_rvalid_c1", rvalid, 1'b0);
        chk("r1_arready_busy", arready, 1'b0);
        tick();
        chk("r1_rvalid_c2", rvalid, 1'b1);
        chk("r1_rdata", rdata, 32'hDEADBEEF);
        chk("r1_rresp", rresp, 2'b00);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r1_rvalid_done", rvalid, 1'b0);

        axi_read(16'h0013, data, resp);
        chk("r_offset_ignored", data, 32'hDEADBEEF);

        // W three cycles ahead of AW
        wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        chk("w2_wready", wready, 1'b1);
        tick();
        wvalid = 1'b0;
        chk("w2_bvalid_c1", bvalid, 1'b0);
        tick();
        chk("w2_bvalid_c2", bvalid, 1'b0);
        tick();
        awaddr = 16'h0020; awvalid = 1'b1;
        chk("w2_awready", awready, 1'b1);
        chk("w2_wready_held", wready, 1'b0);
        tick();
        awvalid = 1'b0;
        chk("w2_bvalid_aw1", bvalid, 1'b0);
        tick();
        chk("w2_bvalid_aw2", bvalid, 1'b1);
        chk("w2_bresp", bresp, 2'b00);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("w2_single_b_a", bvalid, 1'b0);
        tick();
        chk("w2_single_b_b", bvalid, 1'b0);

        axi_write(16'h0020, 32'hAABBCCDD, 4'b0101, resp);
        chk("w_strb_resp", resp, 2'b00);
        axi_read(16'h0020, data, resp);
        chk("w_strb_data", data, 32'h11BB33DD);

        // Out-of-range and zero-strobe writes
        axi_write(16'h0000, 32'h01020304, 4'hF, resp);
        chk("w0_resp", resp, 2'b00);
        axi_write(16'h1000, 32'h55555555, 4'hF, resp);
        chk("oor_bresp", resp, 2'b10);
        axi_write(16'h0000, 32'hFFFFFFFF, 4'h0, resp);
        chk("zero_strb_resp", resp, 2'b00);
        axi_read(16'h0000, data, resp);
        chk("mem_unchanged", data, 32'h01020304);
        axi_read(16'h1000, data, resp);
        chk("oor_rresp", resp, 2'b10);
        chk("oor_rdata", data, 32'h0);
`ifdef AXIL_RAM_ERRCNT_EN
        chk("errcnt_two", err_count, 16'd2);
`endif

        // Contended write/read to the same word
        axi_write(16'h0040, 32'h0, 4'hF, resp);
        for (int i = 0; i < 4; i++) begin
            contend(ct_data[i], bc, rc, data);
            chk($sformatf("ct%0d_bcyc", i), bc, ct_bc[i]);
            chk($sformatf("ct%0d_rcyc", i), rc, ct_rc[i]);
            chk($sformatf("ct%0d_rdata", i), data, ct_rd[i]);
        end

        // B back-pressure stalls the next commit
        awaddr = 16'h0050; wdata = 32'h00005050; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("bp_bvalid1", bvalid, 1'b1);
        awaddr = 16'h0054; wdata = 32'h00005454; awvalid = 1'b1; wvalid = 1'b1;
        chk("bp_second_accept", awready && wready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_awready_stall", awready, 1'b0);
            chk("bp_wready_stall", wready, 1'b0);
            chk("bp_bvalid_hold", bvalid, 1'b1);
            if (i < 3) tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bp_gap", bvalid, 1'b0);
        tick();
        chk("bp_bvalid2", bvalid, 1'b1);
        chk("bp_awready_free", awready, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(16'h0050, data, resp);
        chk("bp_rd50", data, 32'h00005050);
        axi_read(16'h0054, data, resp);
        chk("bp_rd54", data, 32'h00005454);

        // READ_LATENCY=3 instance: latency, stability, then reset mid-read
        araddr3 = 16'h1000; arvalid3 = 1'b1; rready3 = 1'b0;
        chk("l3_arready", arready3, 1'b1);
        tick();
        arvalid3 = 1'b0;
        chk("l3_rvalid_c1", rvalid3, 1'b0);
        tick();
        chk("l3_rvalid_c2", rvalid3, 1'b0);
        tick();
        chk("l3_rvalid_c3", rvalid3, 1'b0);
        tick();
        chk("l3_rvalid_c4", rvalid3, 1'b1);
        chk("l3_rresp", rresp3, 2'b10);
        chk("l3_rdata", rdata3, 32'h0);
        tick();
        chk("l3_rvalid_hold", rvalid3, 1'b1);
        chk("l3_rresp_hold", rresp3, 2'b10);
        rready3 = 1'b1;
        tick();
        rready3 = 1'b0;
        chk("l3_rvalid_done", rvalid3, 1'b0);
        chk("l3_arready_again", arready3, 1'b1);

        araddr3 = 16'h0000; arvalid3 = 1'b1; rready3 = 1'b1;
        tick();
        arvalid3 = 1'b0;
        tick();
        rst3 = 1'b1;
        #1;
        chk("l3r_arready_in_rst", arready3, 1'b0);
        tick();
        chk("l3r_rvalid_in_rst", rvalid3, 1'b0);
        tick();
        rst3 = 1'b0;
        #1;
        chk("l3r_arready_post", arready3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("l3r_no_rvalid_%0d", i), rvalid3, 1'b0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
